// File: rtl/cim_pkg.sv
// Shared definitions for the CIM operand loader: FSM states, word/lane
// geometry derived from the SRAM and operand widths, and lane packing.
package cim_pkg;

  localparam int LANES           = 256;
  localparam int DATA_WIDTH      = 8;
  localparam int SRAM_ADDR_WIDTH = 17;
  localparam int SRAM_DATA_WIDTH = 32;

  // One SRAM word carries this many lane operands.
  localparam int BYTES_PER_WORD  = SRAM_DATA_WIDTH / DATA_WIDTH;
  // Words needed to fill one LANES-wide vector.
  localparam int WORDS           = LANES / BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IN = 3'd1,
    LOAD_WT = 3'd2,
    DRAIN   = 3'd3,
    FIRE    = 3'd4,
    WAIT    = 3'd5
  } state_t;

  // Bit offset of a lane inside a packed operand vector.
  function automatic int lane_offset(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/cim_vec_capture.sv
// Operand vector register: each write drops one SRAM word into the
// BYTES_PER_WORD consecutive lanes selected by the word index.
module cim_vec_capture
  import cim_pkg::*;
#(
  parameter int LANES           = cim_pkg::LANES,
  parameter int DATA_WIDTH      = cim_pkg::DATA_WIDTH,
  parameter int SRAM_DATA_WIDTH = cim_pkg::SRAM_DATA_WIDTH,
  parameter int IDX_WIDTH       = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [IDX_WIDTH-1:0]        idx,
  input  logic [SRAM_DATA_WIDTH-1:0]  word,
  output logic [LANES*DATA_WIDTH-1:0] vec
);

  localparam int BPW = SRAM_DATA_WIDTH / DATA_WIDTH;

  // Scatter the bytes of the incoming word into their lanes.
  // NOTE: the whole vector is cleared on reset because it is a flop bank
  // driven straight to the MAC array, not a RAM macro; zero is its defined idle value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
    end else if (we) begin
      for (int j = 0; j < BPW; j++) begin
        vec[lane_offset(int'(idx) * BPW + j, DATA_WIDTH) +: DATA_WIDTH] <=
          word[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/cim_operand_loader.sv
// Sequencer between CIM SRAM port B and the MAC array: bursts input words
// then weight words, unpacks them into lane vectors, fires the MAC array
// and reports completion once the array signals mac_done.
module cim_operand_loader
  import cim_pkg::*;
#(
  parameter int LANES           = cim_pkg::LANES,
  parameter int DATA_WIDTH      = cim_pkg::DATA_WIDTH,
  parameter int SRAM_ADDR_WIDTH = cim_pkg::SRAM_ADDR_WIDTH,
  parameter int SRAM_DATA_WIDTH = cim_pkg::SRAM_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SRAM_ADDR_WIDTH-1:0]  input_base,
  input  logic [SRAM_ADDR_WIDTH-1:0]  weight_base,
  output logic                        busy,
  output logic                        done,
  output logic [SRAM_ADDR_WIDTH-1:0]  sram_addr_b,
  output logic                        sram_en_b,
  input  logic [SRAM_DATA_WIDTH-1:0]  sram_rdata_b,
  output logic [LANES*DATA_WIDTH-1:0] input_vec,
  output logic [LANES*DATA_WIDTH-1:0] weight_vec,
  output logic                        mac_start,
  input  logic                        mac_done
);

  localparam int BPW   = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int NWORD = LANES / BPW;
  localparam int CNT_W = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORD - 1);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [SRAM_ADDR_WIDTH-1:0]   wt_base_q;

  // Read-return pipeline: tags the word arriving one cycle after each read.
  logic                         rd_in_we;
  logic                         rd_wt_we;
  logic [CNT_W-1:0]             rd_idx;

  // Main FSM with registered busy/done/SRAM/mac_start outputs.
  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wt_base_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sram_en_b   <= 1'b0;
      sram_addr_b <= '0;
      mac_start   <= 1'b0;
    end else begin
      done      <= 1'b0;
      mac_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD_IN;
            busy        <= 1'b1;
            sram_en_b   <= 1'b1;
            sram_addr_b <= input_base;
            wt_base_q   <= weight_base;
            cnt         <= '0;
          end
        end
        LOAD_IN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Weight burst follows with no bubble.
            state       <= LOAD_WT;
            sram_addr_b <= wt_base_q;
            cnt         <= '0;
          end else begin
            sram_addr_b <= sram_addr_b + SRAM_ADDR_WIDTH'(1);
          end
        end
        LOAD_WT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state     <= DRAIN;
            sram_en_b <= 1'b0;
          end else begin
            sram_addr_b <= sram_addr_b + SRAM_ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          state     <= FIRE;
          mac_start <= 1'b1;
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mac_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          sram_en_b <= 1'b0;
        end
      endcase
    end
  end

  // Delay read-valid and word index by one cycle to meet returning SRAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_in_we <= 1'b0;
      rd_wt_we <= 1'b0;
      rd_idx   <= '0;
    end else begin
      rd_in_we <= (state == LOAD_IN);
      rd_wt_we <= (state == LOAD_WT);
      rd_idx   <= cnt;
    end
  end

  cim_vec_capture #(
    .LANES           (LANES),
    .DATA_WIDTH      (DATA_WIDTH),
    .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH),
    .IDX_WIDTH       (CNT_W)
  ) u_input_cap (
    .clk  (clk),
    .rst  (rst),
    .we   (rd_in_we),
    .idx  (rd_idx),
    .word (sram_rdata_b),
    .vec  (input_vec)
  );

  cim_vec_capture #(
    .LANES           (LANES),
    .DATA_WIDTH      (DATA_WIDTH),
    .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH),
    .IDX_WIDTH       (CNT_W)
  ) u_weight_cap (
    .clk  (clk),
    .rst  (rst),
    .we   (rd_wt_we),
    .idx  (rd_idx),
    .word (sram_rdata_b),
    .vec  (weight_vec)
  );

endmodule
